zeroriscy_csr_dbg_access: RTL and testbench

Debug-side initiator for the core's CSR access port. It accepts single CSR read/write/set/clear requests from the debug bus, waits until the core is halted and the ID stage is not using the CSR port, then issues exactly one CSR access. It returns the pre-operation CSR value, or an error, to the debug bus. It sits between the ID stage and the CSR register file and multiplexes the CSR port, giving debug priority only in its issue cycle.

---
 rtl/zeroriscy_defines.sv | 26 ++
 rtl/zeroriscy_csr_dbg_access.sv | 111 +++++++++++
 tb/tb_zeroriscy_csr_dbg_access.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/zeroriscy_defines.sv
// Shared zeroriscy encodings: CSR ops, privilege levels,
// and the debug CSR access FSM states.
package zeroriscy_defines;

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } PrivLvl_t;

  typedef enum logic [1:0] {
    DBG_CSR_IDLE,
    DBG_CSR_WAIT_HALT,
    DBG_CSR_ISSUE,
    DBG_CSR_RESP
  } DbgCsrState_t;

endpackage

// File: rtl/zeroriscy_csr_dbg_access.sv
// Debug-side CSR initiator: waits for halt, issues one
// CSR access and returns the old value or an error.
module zeroriscy_csr_dbg_access
  import zeroriscy_defines::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbg_req_i,
  output logic        dbg_gnt_o,
  input  logic [11:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  input  logic [1:0]  dbg_op_i,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  output logic        dbg_busy_o,
  input  logic        core_halted_i,
  input  logic        id_csr_access_i,
  input  logic [11:0] id_csr_addr_i,
  input  logic [31:0] id_csr_wdata_i,
  input  logic [1:0]  id_csr_op_i,
  output logic        csr_access_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  csr_op_o,
  input  logic [31:0] csr_rdata_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  DbgCsrState_t  state;
  logic [11:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    op_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          issue;
  logic          ro_write;

  assign ro_write = (dbg_addr_i[11:10] == CSR_RO_PREFIX)
                 && (dbg_op_i != CSR_OP_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DBG_CSR_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= CSR_OP_NONE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        DBG_CSR_IDLE: begin
          if (dbg_req_i) begin
            addr_q  <= dbg_addr_i;
            wdata_q <= dbg_wdata_i;
            op_q    <= dbg_op_i;
            cnt_q   <= '0;
            if (ro_write) begin
              state   <= DBG_CSR_RESP;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state <= DBG_CSR_WAIT_HALT;
            end
          end
        end
        DBG_CSR_WAIT_HALT: begin
          if (core_halted_i && !id_csr_access_i) begin
            state <= DBG_CSR_ISSUE;
          end else if (cnt_q == CNT_LAST) begin
            state   <= DBG_CSR_RESP;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // Register file commits at this edge, so rdata is the old value.
        DBG_CSR_ISSUE: begin
          rdata_q <= csr_rdata_i;
          err_q   <= 1'b0;
          state   <= DBG_CSR_RESP;
        end
        DBG_CSR_RESP: begin
          state <= DBG_CSR_IDLE;
        end
        default: state <= DBG_CSR_IDLE;
      endcase
    end
  end

  assign issue        = (state == DBG_CSR_ISSUE);
  assign dbg_gnt_o    = (state == DBG_CSR_IDLE);
  assign dbg_busy_o   = (state != DBG_CSR_IDLE);
  assign dbg_rvalid_o = (state == DBG_CSR_RESP);
  assign dbg_rdata_o  = rdata_q;
  assign dbg_err_o    = err_q;

  assign csr_access_o = issue ? 1'b1    : id_csr_access_i;
  assign csr_addr_o   = issue ? addr_q  : id_csr_addr_i;
  assign csr_wdata_o  = issue ? wdata_q : id_csr_wdata_i;
  assign csr_op_o     = issue ? op_q    : id_csr_op_i;

endmodule

// File: tb/tb_zeroriscy_csr_dbg_access.sv
// Scoreboard bench for zeroriscy_csr_dbg_access with a
// small CSR register file model behind the CSR port.
module tb_zeroriscy_csr_dbg_access;
  import zeroriscy_defines::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dbg_req_i = 1'b0;
  logic        dbg_gnt_o;
  logic [11:0] dbg_addr_i = '0;
  logic [31:0] dbg_wdata_i = '0;
  logic [1:0]  dbg_op_i = CSR_OP_NONE;
  logic        dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;
  logic        dbg_err_o;
  logic        dbg_busy_o;
  logic        core_halted_i = 1'b1;
  logic        id_csr_access_i = 1'b0;
  logic [11:0] id_csr_addr_i = '0;
  logic [31:0] id_csr_wdata_i = '0;
  logic [1:0]  id_csr_op_i = CSR_OP_NONE;
  logic        csr_access_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic [1:0]  csr_op_o;
  logic [31:0] csr_rdata_i;

  zeroriscy_csr_dbg_access #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dbg_req_i      (dbg_req_i),
    .dbg_gnt_o      (dbg_gnt_o),
    .dbg_addr_i     (dbg_addr_i),
    .dbg_wdata_i    (dbg_wdata_i),
    .dbg_op_i       (dbg_op_i),
    .dbg_rvalid_o   (dbg_rvalid_o),
    .dbg_rdata_o    (dbg_rdata_o),
    .dbg_err_o      (dbg_err_o),
    .dbg_busy_o     (dbg_busy_o),
    .core_halted_i  (core_halted_i),
    .id_csr_access_i(id_csr_access_i),
    .id_csr_addr_i  (id_csr_addr_i),
    .id_csr_wdata_i (id_csr_wdata_i),
    .id_csr_op_i    (id_csr_op_i),
    .csr_access_o   (csr_access_o),
    .csr_addr_o     (csr_addr_o),
    .csr_wdata_o    (csr_wdata_o),
    .csr_op_o       (csr_op_o),
    .csr_rdata_i    (csr_rdata_i)
  );

  always #5 clk = ~clk;

  // CSR register file model: mepc and mstatus are real, others constant.
  logic [31:0] mepc, mstatus, old_v, new_v;
  always_comb begin
    old_v = {20'hDEAD0, csr_addr_o};
    if (csr_addr_o == 12'h341) old_v = mepc;
    if (csr_addr_o == 12'h300) old_v = mstatus;
    csr_rdata_i = old_v;
    new_v = old_v;
    case (csr_op_o)
      CSR_OP_WRITE: new_v = csr_wdata_o;
      CSR_OP_SET:   new_v = old_v | csr_wdata_o;
      CSR_OP_CLEAR: new_v = old_v & ~csr_wdata_o;
      default:      new_v = old_v;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc    <= 32'h0000_1234;
      mstatus <= 32'h0000_1800;
    end else if (csr_access_o) begin
      if (csr_addr_o == 12'h341) mepc <= new_v;
      if (csr_addr_o == 12'h300) mstatus <= new_v;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  logic [1:0]  last_op;
  logic [11:0] last_addr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dbg_busy_o && csr_access_o && !id_csr_access_i) begin
      acc_cnt   <= acc_cnt + 1;
      last_op   <= csr_op_o;
      last_addr <= csr_addr_o;
    end
    if (dbg_rvalid_o) begin
      if (q.size() == 0) begin
        chk("unexp_rvalid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rdata", dbg_rdata_o, e.rdata);
        chk("err", {31'd0, dbg_err_o}, {31'd0, e.err});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [11:0] a,
                      input logic [31:0] w,
                      input logic [1:0] op,
                      input int lat,
                      input logic [31:0] erd,
                      input logic eerr,
                      input bit push);
    exp_t e;
    chk("gnt_idle", {31'd0, dbg_gnt_o}, 32'd1);
    dbg_req_i   = 1'b1;
    dbg_addr_i  = a;
    dbg_wdata_i = w;
    dbg_op_i    = op;
    @(posedge clk);
    #1;
    dbg_req_i = 1'b0;
    e.rdata = erd;
    e.err   = eerr;
    e.cyc   = cyc + lat - 1;
    if (push) q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic [11:0] a,
                      input logic [31:0] w,
                      input logic [1:0] op,
                      input int lat,
                      input logic [31:0] erd,
                      input logic eerr,
                      input int eacc);
    int base;
    base = acc_cnt;
    send(a, w, op, lat, erd, eerr, 1'b1);
    chk("busy", {31'd0, dbg_busy_o}, 32'd1);
    drain();
    chk("acc_count", acc_cnt - base, eacc);
  endtask

  initial begin
    id_csr_addr_i  = 12'h0AB;
    id_csr_wdata_i = 32'h5555_AAAA;
    id_csr_op_i    = CSR_OP_SET;
    #12;
    chk("rst_gnt", {31'd0, dbg_gnt_o}, 32'd1);
    chk("rst_busy", {31'd0, dbg_busy_o}, 32'd0);
    chk("rst_rvalid", {31'd0, dbg_rvalid_o}, 32'd0);
    chk("rst_rdata", dbg_rdata_o, 32'd0);
    chk("rst_err", {31'd0, dbg_err_o}, 32'd0);
    chk("rst_pt_addr", {20'd0, csr_addr_o}, 32'h0AB);
    chk("rst_pt_op", {30'd0, csr_op_o}, {30'd0, CSR_OP_SET});
    id_csr_op_i = CSR_OP_NONE;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    xact(12'h341, 32'h0, CSR_OP_NONE, 3, 32'h1234, 1'b0, 1);
    chk("read_op", {30'd0, last_op}, {30'd0, CSR_OP_NONE});
    chk("read_addr", {20'd0, last_addr}, 32'h341);

    xact(12'h300, 32'h8, CSR_OP_SET, 3, 32'h1800, 1'b0, 1);
    chk("set_op", {30'd0, last_op}, {30'd0, CSR_OP_SET});
    xact(12'h300, 32'h0, CSR_OP_NONE, 3, 32'h1808, 1'b0, 1);

    xact(12'h300, 32'h800, CSR_OP_CLEAR, 3, 32'h1808, 1'b0, 1);
    xact(12'h300, 32'h0, CSR_OP_NONE, 3, 32'h1008, 1'b0, 1);

    xact(12'hF14, 32'h1, CSR_OP_WRITE, 1, 32'h0, 1'b1, 0);

    core_halted_i = 1'b0;
    xact(12'h341, 32'hFFFF, CSR_OP_WRITE, TO + 1, 32'h0, 1'b1, 0);
    core_halted_i = 1'b1;
    xact(12'h341, 32'h0, CSR_OP_NONE, 3, 32'h1234, 1'b0, 1);

    // ID stage holds the CSR port for three cycles
    id_csr_op_i = CSR_OP_NONE;
    send(12'h341, 32'h0, CSR_OP_NONE, 6, 32'h1234, 1'b0, 1'b1);
    id_csr_access_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pt_access", {31'd0, csr_access_o}, 32'd1);
      chk("pt_addr", {20'd0, csr_addr_o}, 32'h0AB);
      chk("pt_wdata", csr_wdata_o, 32'h5555_AAAA);
      @(posedge clk);
      #1;
    end
    id_csr_access_i = 1'b0;
    drain();

    xact(12'h341, 32'hCAFE, CSR_OP_WRITE, 3, 32'h1234, 1'b0, 1);
    xact(12'h341, 32'h0, CSR_OP_NONE, 3, 32'hCAFE, 1'b0, 1);

    core_halted_i = 1'b0;
    send(12'h300, 32'h0, CSR_OP_NONE, 3, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", {31'd0, dbg_gnt_o}, 32'd1);
    chk("mid_rst_busy", {31'd0, dbg_busy_o}, 32'd0);
    chk("mid_rst_rvalid", {31'd0, dbg_rvalid_o}, 32'd0);
    chk("mid_rst_rdata", dbg_rdata_o, 32'd0);
    chk("mid_rst_err", {31'd0, dbg_err_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    core_halted_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_gnt", {31'd0, dbg_gnt_o}, 32'd1);
    xact(12'h341, 32'h0, CSR_OP_NONE, 3, 32'h1234, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
